// File: rtl/multicycle_control.sv
// Multicycle control FSM for a single-port-memory RISC-V datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB for lh, sh, andi, bne, add and sll.
// Memory accesses use a req/ready handshake with a bounded wait, and
// unsupported encodings or memory timeouts park the FSM in a sticky TRAP.
// Retired instructions are counted, wrapping silently at 2^CNT_W.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src_b,
   output logic [3:0]       alu_ctrl,
   output logic             illegal,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);
   // The wait counter only has to reach MEM_TIMEOUT-1: the cycle that would
   // take it to MEM_TIMEOUT goes straight to TRAP instead.
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_NONE = 3'd0,
      C_LH   = 3'd1,
      C_SH   = 3'd2,
      C_ANDI = 3'd3,
      C_BNE  = 3'd4,
      C_ADD  = 3'd5,
      C_SLL  = 3'd6
   } class_t;

   state_t            state_q;
   class_t            class_q;
   class_t            dec_class;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  retired_q;
   logic              illegal_q;

   // Classify the IR fields; C_NONE marks an unsupported encoding.
   always_comb begin
      dec_class = C_NONE;
      case (opcode)
         7'b0000011: if (funct3 == 3'b001) dec_class = C_LH;
         7'b0100011: if (funct3 == 3'b001) dec_class = C_SH;
         7'b0010011: if (funct3 == 3'b111) dec_class = C_ANDI;
         7'b1100011: if (funct3 == 3'b001) dec_class = C_BNE;
         7'b0110011: begin
            if (funct7 == 7'b0000000 && funct3 == 3'b000)      dec_class = C_ADD;
            else if (funct7 == 7'b0000000 && funct3 == 3'b001) dec_class = C_SLL;
         end
         default: dec_class = C_NONE;
      endcase
   end

   // Datapath strobes decoded from the state; handshake-qualified ones follow mem_ready directly.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
         end
         S_EXEC: begin
            if (class_q == C_BNE) begin
               pc_write = 1'b1;
               pc_src   = ~zero;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = (class_q == C_SH);
            pc_write = mem_ready && (class_q == C_SH);
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (class_q == C_LH);
            pc_write   = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU operation is only meaningful while the latched class drives the datapath.
   always_comb begin
      alu_ctrl  = ALU_AND;
      alu_src_b = 1'b0;
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         case (class_q)
            C_LH, C_SH: begin alu_ctrl = ALU_ADD; alu_src_b = 1'b1; end
            C_ANDI:     begin alu_ctrl = ALU_AND; alu_src_b = 1'b1; end
            C_ADD:      alu_ctrl = ALU_ADD;
            C_SLL:      alu_ctrl = ALU_SLL;
            C_BNE:      alu_ctrl = ALU_SUB;
            default:    ;
         endcase
      end
   end

   // Sequencer: state, latched class, handshake wait counter, trap flag and retire count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         class_q   <= C_NONE;
         wait_q    <= '0;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
               wait_q  <= '0;
            end
            S_FETCH, S_MEM: begin
               if (mem_ready) begin
                  wait_q <= '0;
                  if (state_q == S_FETCH)    state_q <= S_DECODE;
                  else if (class_q == C_SH)  state_q <= S_FETCH;
                  else                       state_q <= S_WB;
               end else if (wait_q == WAIT_LAST) begin
                  wait_q    <= '0;
                  state_q   <= S_TRAP;
                  illegal_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               class_q <= dec_class;
               wait_q  <= '0;
               if (dec_class == C_NONE) begin
                  state_q   <= S_TRAP;
                  illegal_q <= 1'b1;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               wait_q <= '0;
               case (class_q)
                  C_BNE:               state_q <= S_FETCH;
                  C_LH, C_SH:          state_q <= S_MEM;
                  C_ANDI, C_ADD, C_SLL: state_q <= S_WB;
                  default: begin
                     state_q   <= S_TRAP;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            S_WB: begin
               wait_q  <= '0;
               state_q <= S_FETCH;
            end
            S_TRAP:  state_q <= S_TRAP;
            default: begin
               state_q   <= S_TRAP;
               illegal_q <= 1'b1;
            end
         endcase
         // Every retiring instruction updates the PC exactly once.
         if (pc_write) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign state   = state_q;
   assign retired = retired_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver plans each instruction
// from the instruction rules and pushes expected handshake/retire/trap events;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_multicycle_control;
   localparam int T  = 15;
   localparam int CW = 2;
   localparam int K_LH = 0, K_SH = 1, K_ANDI = 2, K_BNE = 3, K_ADD = 4, K_SLL = 5, K_ILL = 6;
   localparam int EV_FETCH = 0, EV_MEM = 1, EV_RET = 2, EV_TRAP = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    opcode = '0;
   logic [2:0]    funct3 = '0;
   logic [6:0]    funct7 = '0;
   logic          zero = 1'b0;
   logic          mem_ready = 1'b0;
   logic          mem_req, mem_we, ir_write, pc_write, pc_src;
   logic          reg_write, mem_to_reg, alu_src_b, illegal;
   logic [3:0]    alu_ctrl;
   logic [2:0]    state;
   logic [CW-1:0] retired;

   multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .illegal(illegal), .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instruction table indexed by kind: encoding, ALU op, ALU B source.
   logic [6:0] tab_op [6] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b1100011, 7'b0110011, 7'b0110011};
   logic [2:0] tab_f3 [6] = '{3'd1, 3'd1, 3'd7, 3'd1, 3'd0, 3'd1};
   bit         tab_r  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   int         tab_alu[6] = '{2, 2, 0, 6, 2, 3};
   int         tab_srcb[6] = '{1, 1, 1, 0, 0, 0};

   typedef struct {
      int kind; int cyc; int st;
      int mem_req; int mem_we; int ir_write; int pc_write; int pc_src;
      int reg_write; int mem_to_reg; int alu_src_b; int alu_ctrl; int illegal; int retired;
   } exp_t;

   exp_t exp_q[$];
   int   rc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   in_trap = 1'b0;

   function automatic void cmp(input string tag, input string f, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s.%s actual=%0d expected=%0d (cycle %0d)", tag, f, act, want, cyc);
      end
   endfunction

   function automatic exp_t mk(input int kind, input int c, input int st);
      exp_t e;
      e.kind = kind; e.cyc = c; e.st = st;
      e.mem_req = 0; e.mem_we = 0; e.ir_write = 0; e.pc_write = 0; e.pc_src = 0;
      e.reg_write = 0; e.mem_to_reg = 0; e.alu_src_b = 0; e.alu_ctrl = 0; e.illegal = 0;
      e.retired = rc % (1 << CW);
      return e;
   endfunction

   function automatic void push_fetch(input int c);
      exp_t e;
      e = mk(EV_FETCH, c, 1);
      e.mem_req = 1; e.ir_write = 1;
      exp_q.push_back(e);
   endfunction

   function automatic void push_mem(input int k, input int c);
      exp_t e;
      e = mk(EV_MEM, c, 4);
      e.mem_req = 1; e.mem_we = (k == K_SH) ? 1 : 0; e.pc_write = (k == K_SH) ? 1 : 0;
      e.alu_ctrl = 2; e.alu_src_b = 1;
      exp_q.push_back(e);
   endfunction

   function automatic void push_ret(input int k, input int c, input bit z);
      exp_t e;
      if (k == K_BNE) begin
         e = mk(EV_RET, c, 3);
         e.pc_src = z ? 0 : 1;
      end else if (k == K_SH) begin
         e = mk(EV_RET, c, 4);
         e.mem_req = 1; e.mem_we = 1;
      end else begin
         e = mk(EV_RET, c, 5);
         e.reg_write = 1; e.mem_to_reg = (k == K_LH) ? 1 : 0;
      end
      e.pc_write = 1; e.alu_ctrl = tab_alu[k]; e.alu_src_b = tab_srcb[k];
      exp_q.push_back(e);
      rc++;
   endfunction

   function automatic void push_trap(input int c);
      exp_t e;
      e = mk(EV_TRAP, c, 6);
      e.illegal = 1;
      exp_q.push_back(e);
   endfunction

   function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      for (int k = 0; k < 6; k++)
         if (op == tab_op[k] && f3 == tab_f3[k] && (!tab_r[k] || f7 == 7'd0)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pick_stall();
      int r;
      r = int'($urandom_range(0, 9));
      return (r == 0) ? T - 1 : int'($urandom_range(0, 3));
   endfunction

   task automatic check_event(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s unexpected event at cycle %0d state=%0d expected none", tag, cyc, state);
      end else begin
         e = exp_q.pop_front();
         $display("EV %s kind=%0d cyc=%0d state=%0d pc_write=%0d reg_write=%0d mem_we=%0d alu=%0d retired=%0d",
                  tag, e.kind, cyc, state, pc_write, reg_write, mem_we, alu_ctrl, retired);
         cmp(tag, "cycle", cyc, e.cyc);
         cmp(tag, "state", int'(state), e.st);
         cmp(tag, "mem_req", int'(mem_req), e.mem_req);
         cmp(tag, "mem_we", int'(mem_we), e.mem_we);
         cmp(tag, "ir_write", int'(ir_write), e.ir_write);
         cmp(tag, "pc_write", int'(pc_write), e.pc_write);
         cmp(tag, "reg_write", int'(reg_write), e.reg_write);
         cmp(tag, "alu_ctrl", int'(alu_ctrl), e.alu_ctrl);
         cmp(tag, "alu_src_b", int'(alu_src_b), e.alu_src_b);
         cmp(tag, "illegal", int'(illegal), e.illegal);
         cmp(tag, "retired", int'(retired), e.retired);
         if (e.kind == EV_RET) begin
            cmp(tag, "pc_src", int'(pc_src), e.pc_src);
            cmp(tag, "mem_to_reg", int'(mem_to_reg), e.mem_to_reg);
         end
      end
   endtask

   // Monitor: one look per cycle on the falling edge.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_trap = 1'b0;
         end else begin
            cmp("cycle", "wr_and_we", int'(reg_write & mem_we), 0);
            if (mem_req && mem_ready) check_event("handshake");
            if (pc_write) check_event("retire");
            if (state == 3'd6 && !in_trap) begin
               in_trap = 1'b1;
               check_event("trap");
            end else if (state != 3'd6) begin
               in_trap = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input int k);
      opcode = tab_op[k];
      funct3 = tab_f3[k];
      funct7 = tab_r[k] ? 7'd0 : 7'($urandom);
   endtask

   // Called in the first FETCH cycle; returns in the next FETCH cycle or in the first TRAP cycle.
   task automatic run_instr(input int k, input int fs, input int ms, input bit z);
      zero = z;
      if (fs >= T) begin
         repeat (T) begin mem_ready = 1'b0; step(); end
         push_trap(cyc);
         return;
      end
      repeat (fs) begin mem_ready = 1'b0; step(); end
      push_fetch(cyc);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'($urandom_range(0, 1));
      if (k == K_ILL) begin
         step();
         push_trap(cyc);
         return;
      end
      step();
      mem_ready = 1'($urandom_range(0, 1));
      if (k == K_BNE) begin
         push_ret(k, cyc, z);
         step();
         return;
      end
      if (k == K_ANDI || k == K_ADD || k == K_SLL) begin
         step();
         push_ret(k, cyc, z);
         mem_ready = 1'($urandom_range(0, 1));
         step();
         return;
      end
      step();
      if (ms >= T) begin
         repeat (T) begin mem_ready = 1'b0; step(); end
         push_trap(cyc);
         return;
      end
      repeat (ms) begin mem_ready = 1'b0; step(); end
      push_mem(k, cyc);
      mem_ready = 1'b1;
      if (k == K_SH) begin
         push_ret(k, cyc, z);
         step();
         return;
      end
      step();
      push_ret(k, cyc, z);
      mem_ready = 1'($urandom_range(0, 1));
      step();
   endtask

   // Reset lands mid-cycle; returns in the first FETCH cycle after release.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      cmp("reset", "state", int'(state), 0);
      cmp("reset", "illegal", int'(illegal), 0);
      cmp("reset", "retired", int'(retired), 0);
      cmp("reset", "mem_req", int'(mem_req), 0);
      cmp("reset", "mem_we", int'(mem_we), 0);
      cmp("reset", "ir_write", int'(ir_write), 0);
      cmp("reset", "pc_write", int'(pc_write), 0);
      cmp("reset", "reg_write", int'(reg_write), 0);
      cmp("reset", "alu_ctrl", int'(alu_ctrl), 0);
      cmp("reset", "alu_src_b", int'(alu_src_b), 0);
      cmp("reset", "queue_empty", exp_q.size(), 0);
      exp_q.delete();
      rc = 0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic trap_hold();
      repeat (3) begin mem_ready = 1'($urandom_range(0, 1)); step(); end
      cmp("trap_hold", "state", int'(state), 6);
      cmp("trap_hold", "illegal", int'(illegal), 1);
      cmp("trap_hold", "retired", int'(retired), rc % (1 << CW));
      cmp("trap_hold", "mem_req", int'(mem_req), 0);
      cmp("trap_hold", "pc_write", int'(pc_write), 0);
      cmp("trap_hold", "reg_write", int'(reg_write), 0);
      do_reset();
   endtask

   initial begin : driver
      int s;
      int k;
      step();
      do_reset();

      s = cyc; set_ir(K_ADD); run_instr(K_ADD, 0, 0, 1'b0);
      cmp("add", "cycles", cyc - s, 4);
      s = cyc; set_ir(K_LH); run_instr(K_LH, 3, 3, 1'b0);
      cmp("lh", "cycles", cyc - s, 11);
      s = cyc; set_ir(K_SH); run_instr(K_SH, 0, 0, 1'b0);
      cmp("sh", "cycles", cyc - s, 4);
      set_ir(K_ANDI); run_instr(K_ANDI, 0, 0, 1'b0);
      s = cyc; set_ir(K_BNE); run_instr(K_BNE, 0, 0, 1'b0);
      cmp("bne_nz", "cycles", cyc - s, 3);
      s = cyc; set_ir(K_BNE); run_instr(K_BNE, 0, 0, 1'b1);
      cmp("bne_z", "cycles", cyc - s, 3);

      // Ready on the last permitted wait cycle is still accepted.
      set_ir(K_ANDI); run_instr(K_ANDI, T - 1, 0, 1'b0);
      set_ir(K_SH);   run_instr(K_SH, 0, T - 1, 1'b0);

      for (int i = 0; i < 60; i++) begin
         k = int'($urandom_range(0, 5));
         set_ir(k);
         run_instr(k, pick_stall(), pick_stall(), 1'($urandom_range(0, 1)));
      end

      // add opcode with the SUB funct7 is not supported.
      opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
      run_instr(K_ILL, 0, 0, 1'b0);
      trap_hold();

      set_ir(K_SLL); run_instr(K_SLL, 0, 0, 1'b0);
      do begin
         opcode = ($urandom_range(0, 1) == 0) ? tab_op[$urandom_range(0, 5)] : 7'($urandom);
         funct3 = 3'($urandom);
         funct7 = 7'($urandom);
      end while (is_legal(opcode, funct3, funct7));
      run_instr(K_ILL, int'($urandom_range(0, 2)), 0, 1'b0);
      trap_hold();

      set_ir(K_ADD); run_instr(K_ADD, T, 0, 1'b0);
      trap_hold();
      set_ir(K_LH); run_instr(K_LH, 0, T, 1'b0);
      trap_hold();

      // Reset while an sh waits in MEM.
      set_ir(K_ADD); run_instr(K_ADD, 0, 0, 1'b0);
      set_ir(K_SH); zero = 1'b0;
      push_fetch(cyc);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      step();
      step();
      step();
      step();
      cmp("midmem", "state", int'(state), 4);
      cmp("midmem", "mem_req", int'(mem_req), 1);
      cmp("midmem", "mem_we", int'(mem_we), 1);
      cmp("midmem", "retired", int'(retired), 1);
      do_reset();

      for (int i = 0; i < 5; i++) begin
         k = int'($urandom_range(0, 5));
         set_ir(k);
         run_instr(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
      cmp("wrap", "retired", int'(retired), 1);

      mem_ready = 1'b0;
      cmp("end", "queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
